// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM states and bus-level constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRackSample,
        StWaitStop
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the raw SCL/SDA pins and derives bus events from the
// synchronised levels.
module i2c_bus_sync (
    input  logic sys_clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [0] metastability stage, [1] synchronised level, [2] previous synchronised level
    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    // Shift pin levels through the synchroniser and edge-history stages.
    always_comb begin
        scl_d = {scl_q[1:0], scl_in};
        sda_d = {sda_q[1:0], sda_in};
    end

    // Reset to the idle-bus level so no spurious edge appears after reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign sda_s     = sda_q[1];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C responder with a byte-addressed register file, pointer auto-increment
// and a local-side write port.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned DEPTH    = 16,
    localparam int unsigned PW      = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          loc_we,
    input  logic [PW-1:0] loc_idx,
    input  logic [7:0]    loc_wdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_idx,
    output logic [7:0]    wr_data,
    output logic          busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [DEPTH];
    logic [7:0]    regs_d [DEPTH];
    logic          bus_we;
    logic [7:0]    rd_byte;

    assign rd_byte = regs_q[ptr_q];

    // Protocol FSM. In ACK states bit_cnt 8 means "ACK not yet driven" and
    // 9 means "ACK on the bus"; in RACK_SAMPLE 9 means "master ACKed".
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        bus_we      = 1'b0;

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: begin
                end
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == StAddr) begin
                                rw_d    = shift_d[0];
                                state_d = (shift_d[7:1] == DEV_ADDR) ? StAddrAck : StWaitStop;
                            end else if (state_q == StPtr) begin
                                state_d = StPtrAck;
                            end else begin
                                state_d = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd9;
                            if (state_q == StPtrAck) begin
                                ptr_d = shift_q[PW-1:0];
                            end else if (state_q == StWdataAck) begin
                                bus_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_idx_d    = ptr_q;
                                wr_data_d   = shift_q;
                                ptr_d       = ptr_q + PW'(1);
                            end
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == StAddrAck && rw_q == RW_READ) begin
                                // First read bit goes out on this same falling edge.
                                shift_d  = rd_byte;
                                ptr_d    = ptr_q + PW'(1);
                                sda_oe_d = ~rd_byte[7];
                                state_d  = StRdata;
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = StRackSample;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                StRackSample: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            bit_cnt_d = 4'd9;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        shift_d   = rd_byte;
                        ptr_d     = ptr_q + PW'(1);
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd0;
                        state_d   = StRdata;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Register file update; the bus write is applied last so it wins a collision.
    always_comb begin
        regs_d = regs_q;
        if (loc_we) begin
            regs_d[loc_idx] = loc_wdata;
        end
        if (bus_we) begin
            regs_d[ptr_q] = shift_q;
        end
    end

    // State and register-file flops.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            rw_q        <= RW_WRITE;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= 8'h00;
            regs_q      <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_idx    = wr_idx_q;
    assign wr_data   = wr_data_q;

endmodule
